// File: rtl/pipe_latch_skid.sv
// Inter-stage pipeline latch with a two-entry skid buffer, flush, bubble injection
// and a saturating back-pressure counter.
module pipe_latch_skid #(
  parameter int unsigned            IR_WIDTH    = 16,
  parameter int unsigned            PC_WIDTH    = 16,
  parameter int unsigned            SB_WIDTH    = 1,
  parameter logic [IR_WIDTH-1:0]    NOP_WORD    = '0,
  parameter int unsigned            STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IR_WIDTH-1:0]    in_ir,
  input  logic [PC_WIDTH-1:0]    in_pc,
  input  logic [SB_WIDTH-1:0]    in_sb,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IR_WIDTH-1:0]    out_ir,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic [SB_WIDTH-1:0]    out_sb,
  output logic                   out_nop,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic                   r_main_v, r_skid_v;
  logic [IR_WIDTH-1:0]    r_main_ir, r_skid_ir;
  logic [PC_WIDTH-1:0]    r_main_pc, r_skid_pc;
  logic [SB_WIDTH-1:0]    r_main_sb, r_skid_sb;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic                   w_main_v_d, w_skid_v_d;
  logic [IR_WIDTH-1:0]    w_main_ir_d, w_skid_ir_d;
  logic [PC_WIDTH-1:0]    w_main_pc_d, w_skid_pc_d;
  logic [SB_WIDTH-1:0]    w_main_sb_d, w_skid_sb_d;
  logic [STALL_CNT_W-1:0] w_stall_cnt_d;
  logic                   w_accept, w_pop;

  // in_ready depends only on the skid register, never on in_valid/out_ready.
  assign w_accept = in_valid && !r_skid_v;
  assign w_pop    = r_main_v && out_ready;

  always_comb begin
    w_main_v_d  = r_main_v;
    w_main_ir_d = r_main_ir;
    w_main_pc_d = r_main_pc;
    w_main_sb_d = r_main_sb;
    w_skid_v_d  = r_skid_v;
    w_skid_ir_d = r_skid_ir;
    w_skid_pc_d = r_skid_pc;
    w_skid_sb_d = r_skid_sb;
    if (flush) begin
      w_main_v_d = 1'b0;
      w_skid_v_d = 1'b0;
    end else if (!r_main_v) begin
      if (w_accept) begin
        w_main_v_d  = 1'b1;
        w_main_ir_d = in_ir;
        w_main_pc_d = in_pc;
        w_main_sb_d = in_sb;
      end
    end else if (!r_skid_v) begin
      if (w_accept && w_pop) begin
        w_main_ir_d = in_ir;
        w_main_pc_d = in_pc;
        w_main_sb_d = in_sb;
      end else if (w_pop) begin
        w_main_v_d = 1'b0;
      end else if (w_accept) begin
        w_skid_v_d  = 1'b1;
        w_skid_ir_d = in_ir;
        w_skid_pc_d = in_pc;
        w_skid_sb_d = in_sb;
      end
    end else if (w_pop) begin
      w_main_ir_d = r_skid_ir;
      w_main_pc_d = r_skid_pc;
      w_main_sb_d = r_skid_sb;
      w_skid_v_d  = 1'b0;
    end
  end

  always_comb begin
    w_stall_cnt_d = r_stall_cnt;
    if (r_main_v && !out_ready && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
      w_stall_cnt_d = r_stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_v    <= 1'b0;
      r_main_ir   <= '0;
      r_main_pc   <= '0;
      r_main_sb   <= '0;
      r_skid_v    <= 1'b0;
      r_skid_ir   <= '0;
      r_skid_pc   <= '0;
      r_skid_sb   <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_main_v    <= w_main_v_d;
      r_main_ir   <= w_main_ir_d;
      r_main_pc   <= w_main_pc_d;
      r_main_sb   <= w_main_sb_d;
      r_skid_v    <= w_skid_v_d;
      r_skid_ir   <= w_skid_ir_d;
      r_skid_pc   <= w_skid_pc_d;
      r_skid_sb   <= w_skid_sb_d;
      r_stall_cnt <= w_stall_cnt_d;
    end
  end

  assign in_ready  = !r_skid_v;
  assign out_valid = r_main_v;
  assign out_nop   = !r_main_v;
  assign out_ir    = r_main_v ? r_main_ir : NOP_WORD;
  assign out_pc    = r_main_pc;
  assign out_sb    = r_main_v ? r_main_sb : '0;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_latch_skid.sv
// Scoreboard bench for pipe_latch_skid: directed scenarios followed by random valid/ready
// traffic, checked against an in-order queue model of the held entries.
module tb_pipe_latch_skid;

  localparam int unsigned IRW = 16;
  localparam int unsigned PCW = 16;
  localparam int unsigned SBW = 1;
  localparam int unsigned SCW = 4;
  localparam logic [IRW-1:0] NOP = 16'h0000;

  typedef struct packed {
    logic [IRW-1:0] ir;
    logic [PCW-1:0] pc;
    logic [SBW-1:0] sb;
  } ent_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [IRW-1:0] in_ir = '0;
  logic [PCW-1:0] in_pc = '0;
  logic [SBW-1:0] in_sb = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [IRW-1:0] out_ir;
  logic [PCW-1:0] out_pc;
  logic [SBW-1:0] out_sb;
  logic           out_nop;
  logic [SCW-1:0] stall_cnt;

  pipe_latch_skid #(
    .IR_WIDTH   (IRW),
    .PC_WIDTH   (PCW),
    .SB_WIDTH   (SBW),
    .NOP_WORD   (NOP),
    .STALL_CNT_W(SCW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ir    (in_ir),
    .in_pc    (in_pc),
    .in_sb    (in_sb),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ir   (out_ir),
    .out_pc   (out_pc),
    .out_sb   (out_sb),
    .out_nop  (out_nop),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t exp_q[$];
  int   m_cnt    = 0;
  bit   started  = 1'b0;
  bit   prev_rst = 1'b0;
  int   pend, occ;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // One cycle of stimulus; inputs change just after the rising edge.
  task automatic cyc(input logic v, input logic [IRW-1:0] ir, input logic [PCW-1:0] pc,
                     input logic [SBW-1:0] sb, input logic rdy, input logic fl, input logic r);
    ent_t e;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_ir     = ir;
    in_pc     = pc;
    in_sb     = sb;
    out_ready = rdy;
    flush     = fl;
    rst       = r;
    if (in_valid && in_ready && !flush && !rst) begin
      e.ir = ir;
      e.pc = pc;
      e.sb = sb;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: mid-cycle, the model's held entries are the queue minus any entry being offered now.
  always @(negedge clk) begin
    if (started) begin
      pend = (in_valid && in_ready && !flush && !rst) ? 1 : 0;
      occ  = exp_q.size() - pend;
      chk("out_valid", {31'd0, out_valid}, {31'd0, occ > 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, occ < 2});
      chk("stall_cnt", {28'd0, stall_cnt}, m_cnt);
      if (prev_rst) chk("out_pc_after_rst", {16'd0, out_pc}, 32'd0);
      if (occ == 0) begin
        chk("out_nop", {31'd0, out_nop}, 32'd1);
        chk("out_ir_bubble", {16'd0, out_ir}, {16'd0, NOP});
        chk("out_sb_bubble", {31'd0, out_sb}, 32'd0);
      end else begin
        chk("out_nop", {31'd0, out_nop}, 32'd0);
        chk("out_ir", {16'd0, out_ir}, {16'd0, exp_q[0].ir});
        chk("out_pc", {16'd0, out_pc}, {16'd0, exp_q[0].pc});
        chk("out_sb", {31'd0, out_sb}, {31'd0, exp_q[0].sb});
        if (out_ready) void'(exp_q.pop_front());
        else if (m_cnt != (1 << SCW) - 1) m_cnt++;
      end
      if (rst) begin
        exp_q.delete();
        m_cnt = 0;
      end else if (flush) begin
        exp_q.delete();
      end
    end
    prev_rst = rst;
    if (rst) started = 1'b1;
  end

  initial begin
    // Reset, then stream three entries with downstream always ready.
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 16'h1111, 16'h0100, 1, 1, 0, 0);
    cyc(1, 16'h2222, 16'h0102, 0, 1, 0, 0);
    cyc(1, 16'h3333, 16'h0104, 1, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 1, 0, 0);

    // Back-pressure into the skid slot, hold, then release.
    cyc(1, 16'h1111, 16'h0200, 0, 0, 0, 0);
    cyc(1, 16'h2222, 16'h0202, 1, 0, 0, 0);
    cyc(1, 16'h5555, 16'h0204, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 1, 0, 0);

    // Flush from the skid state while a new entry is offered.
    cyc(1, 16'h0aaa, 16'h0300, 0, 0, 0, 0);
    cyc(1, 16'h0bbb, 16'h0302, 1, 0, 0, 0);
    cyc(1, 16'h4444, 16'h0304, 1, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 1, 0, 0);

    // Stall-counter saturation, then reset clears it.
    cyc(1, 16'h6666, 16'h0400, 0, 0, 0, 0);
    repeat ((1 << SCW) + 5) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 0, 0);

    // Reset from the skid state, then reset together with flush.
    cyc(1, 16'h7001, 16'h0500, 1, 0, 0, 0);
    cyc(1, 16'h7002, 16'h0502, 0, 0, 0, 0);
    cyc(1, 16'h7003, 16'h0504, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 16'h7004, 16'h0506, 1, 0, 0, 0);
    cyc(1, 16'h7005, 16'h0508, 1, 0, 0, 0);
    cyc(1, 16'h7006, 16'h050a, 0, 1, 1, 1);
    cyc(0, 0, 0, 0, 1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      cyc(($urandom_range(99) < 70) ? 1'b1 : 1'b0,
          IRW'($urandom), PCW'($urandom), SBW'($urandom),
          ($urandom_range(99) < 60) ? 1'b1 : 1'b0,
          ($urandom_range(999) < 10) ? 1'b1 : 1'b0,
          ($urandom_range(999) < 2) ? 1'b1 : 1'b0);
    end

    repeat (5) cyc(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
